// File: rtl/relay_sequencer.sv
// Sequences a DC precharge relay and an AC mains relay with settle, gap and
// hold-off timing, plus an e-stop interlock that forces both relays open.
module relay_sequencer #(
  parameter int unsigned DC_SETTLE_CYC = 1600000,
  parameter int unsigned AC_GAP_CYC    = 320000,
  parameter int unsigned MIN_OFF_CYC   = 3200000,
  parameter int unsigned TMR_W         = 24,
  parameter int unsigned BLINK_BIT     = 22
) (
  input  logic       clkPin106,
  input  logic       rstN,
  input  logic       reqDC,
  input  logic       reqAC,
  input  logic       faultN,
  output logic       relayDCOut,
  output logic       relayACOut,
  output logic       ledDCOut,
  output logic       ledACOut,
  output logic [2:0] stateOut
);

  localparam logic [2:0] S_OFF       = 3'd0;
  localparam logic [2:0] S_DC_SETTLE = 3'd1;
  localparam logic [2:0] S_DC_ON     = 3'd2;
  localparam logic [2:0] S_AC_ON     = 3'd3;
  localparam logic [2:0] S_AC_DROP   = 3'd4;
  localparam logic [2:0] S_HOLDOFF   = 3'd5;
  localparam logic [2:0] S_FAULT     = 3'd6;

  localparam int unsigned CNT_W = BLINK_BIT + 1;

  localparam logic [TMR_W-1:0] SETTLE_LOAD  = TMR_W'(DC_SETTLE_CYC - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD     = TMR_W'(AC_GAP_CYC - 1);
  localparam logic [TMR_W-1:0] HOLDOFF_LOAD = TMR_W'(MIN_OFF_CYC - 1);

  logic             fault_meta;
  logic             fault_sync;
  logic             fault;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [TMR_W-1:0] timer;
  logic [TMR_W-1:0] timer_next;
  logic             timer_done;
  logic [CNT_W-1:0] blink_cnt;
  logic [CNT_W-1:0] blink_cnt_next;
  logic             blink;
  logic             dc_next;
  logic             ac_next;
  logic             led_dc_next;
  logic             led_ac_next;

  // The e-stop is asynchronous; both flops idle high so reset means "no fault".
  always_ff @(posedge clkPin106 or negedge rstN) begin
    if (!rstN) begin
      fault_meta <= 1'b1;
      fault_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make both flops sample on the same edge,
      // giving a true two-stage synchronizer rather than a single wire.
      fault_meta <= faultN;
      fault_sync <= fault_meta;
    end
  end

  assign fault          = ~fault_sync;
  assign timer_done     = (timer == '0);
  assign blink_cnt_next = blink_cnt + CNT_W'(1);
  assign blink          = blink_cnt_next[BLINK_BIT];

  always_comb begin
    // NOTE: defaulting the next state first keeps every path assigned, so no
    // latch is inferred for the cases that simply hold.
    state_next = state;
    if (fault) begin
      state_next = S_FAULT;
    end else begin
      case (state)
        S_OFF:       if (reqDC) state_next = S_DC_SETTLE;
        S_DC_SETTLE: begin
          if (!reqDC)          state_next = S_HOLDOFF;
          else if (timer_done) state_next = S_DC_ON;
        end
        S_DC_ON: begin
          if (!reqDC)     state_next = S_HOLDOFF;
          else if (reqAC) state_next = S_AC_ON;
        end
        S_AC_ON:     if (!reqAC || !reqDC) state_next = S_AC_DROP;
        S_AC_DROP:   if (timer_done) state_next = reqDC ? S_DC_ON : S_HOLDOFF;
        S_HOLDOFF:   if (timer_done) state_next = S_OFF;
        S_FAULT:     if (!reqDC && !reqAC) state_next = S_HOLDOFF;
        default:     state_next = S_FAULT;
      endcase
    end
  end

  // Timed states load N-1 on entry and leave on the cycle the timer reads 0.
  always_comb begin
    timer_next = timer;
    if (state_next != state) begin
      case (state_next)
        S_DC_SETTLE: timer_next = SETTLE_LOAD;
        S_AC_DROP:   timer_next = GAP_LOAD;
        S_HOLDOFF:   timer_next = HOLDOFF_LOAD;
        default:     timer_next = '0;
      endcase
    end else if (!timer_done) begin
      timer_next = timer - TMR_W'(1);
    end
  end

  always_comb begin
    dc_next     = 1'b0;
    ac_next     = 1'b0;
    led_dc_next = 1'b0;
    led_ac_next = 1'b0;
    case (state_next)
      S_DC_SETTLE: begin
        dc_next     = 1'b1;
        led_dc_next = blink;
      end
      S_DC_ON: begin
        dc_next     = 1'b1;
        led_dc_next = 1'b1;
      end
      S_AC_ON: begin
        dc_next     = 1'b1;
        ac_next     = 1'b1;
        led_dc_next = 1'b1;
        led_ac_next = 1'b1;
      end
      S_AC_DROP: begin
        dc_next     = 1'b1;
        led_dc_next = 1'b1;
        led_ac_next = blink;
      end
      S_FAULT: begin
        led_dc_next = blink;
        led_ac_next = blink;
      end
      default: ;
    endcase
  end

  // Outputs are decoded from the next state so relays move on the same edge
  // as the state register; reset drops them without any sequencing.
  always_ff @(posedge clkPin106 or negedge rstN) begin
    if (!rstN) begin
      state      <= S_OFF;
      timer      <= '0;
      blink_cnt  <= '0;
      relayDCOut <= 1'b0;
      relayACOut <= 1'b0;
      ledDCOut   <= 1'b0;
      ledACOut   <= 1'b0;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      blink_cnt  <= blink_cnt_next;
      relayDCOut <= dc_next;
      relayACOut <= ac_next;
      ledDCOut   <= led_dc_next;
      ledACOut   <= led_ac_next;
    end
  end

  assign stateOut = state;

endmodule

// File: tb/tb_relay_sequencer.sv
// Directed bench for relay_sequencer: an age-counting behavioural model is
// compared against the DUT every cycle, with literal checks at key points.
module tb_relay_sequencer;

  localparam int DC_N  = 4;
  localparam int GAP_N = 3;
  localparam int OFF_N = 5;
  localparam int BB    = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_dc = 1'b0;
  logic       req_ac = 1'b0;
  logic       fault_n = 1'b1;
  logic       relay_dc;
  logic       relay_ac;
  logic       led_dc;
  logic       led_ac;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;

  relay_sequencer #(
    .DC_SETTLE_CYC(DC_N),
    .AC_GAP_CYC   (GAP_N),
    .MIN_OFF_CYC  (OFF_N),
    .TMR_W        (24),
    .BLINK_BIT    (BB)
  ) dut (
    .clkPin106 (clk),
    .rstN      (rst_n),
    .reqDC     (req_dc),
    .reqAC     (req_ac),
    .faultN    (fault_n),
    .relayDCOut(relay_dc),
    .relayACOut(relay_ac),
    .ledDCOut  (led_dc),
    .ledACOut  (led_ac),
    .stateOut  (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: state plus "edges spent in this state" and a two-deep
  // history of the e-stop input.
  int m_state = 0;
  int m_age   = 0;
  int m_edges = 0;
  int m_nxt;
  bit fh0 = 1'b1;
  bit fh1 = 1'b1;

  function automatic int model_next(input int cur, input int age, input bit f_ok,
                                    input bit rdc, input bit rac);
    if (!f_ok) return 6;
    case (cur)
      0: return rdc ? 1 : 0;
      1: return !rdc ? 5 : ((age == DC_N - 1) ? 2 : 1);
      2: return !rdc ? 5 : (rac ? 3 : 2);
      3: return (!rdc || !rac) ? 4 : 3;
      4: return (age == GAP_N - 1) ? (rdc ? 2 : 5) : 4;
      5: return (age == OFF_N - 1) ? 0 : 5;
      default: return (!rdc && !rac) ? 5 : 6;
    endcase
  endfunction

  always_comb m_nxt = model_next(m_state, m_age, fh1, req_dc, req_ac);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_age   <= 0;
      m_edges <= 0;
      fh0     <= 1'b1;
      fh1     <= 1'b1;
    end else begin
      m_state <= m_nxt;
      m_age   <= (m_nxt == m_state) ? m_age + 1 : 0;
      m_edges <= m_edges + 1;
      fh0     <= fault_n;
      fh1     <= fh0;
    end
  end

  function automatic bit exp_dc(input int s);
    return (s >= 1 && s <= 4);
  endfunction

  function automatic bit exp_led_dc(input int s, input int e);
    bit b = ((e >> BB) & 1) != 0;
    case (s)
      1, 6:    return b;
      2, 3, 4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit exp_led_ac(input int s, input int e);
    bit b = ((e >> BB) & 1) != 0;
    case (s)
      3:       return 1'b1;
      4, 6:    return b;
      default: return 1'b0;
    endcase
  endfunction

  // Per-cycle compare on the falling edge, plus the relay-change invariant.
  logic prev_dc = 1'b0;
  logic prev_ac = 1'b0;
  always @(negedge clk) begin
    check("state", {29'd0, state}, m_state);
    check("relay_dc", {31'd0, relay_dc}, {31'd0, exp_dc(m_state)});
    check("relay_ac", {31'd0, relay_ac}, {31'd0, (m_state == 3)});
    check("led_dc", {31'd0, led_dc}, {31'd0, exp_led_dc(m_state, m_edges)});
    check("led_ac", {31'd0, led_ac}, {31'd0, exp_led_ac(m_state, m_edges)});
    if (rst_n) begin
      check("dc_ac_same_edge",
            {31'd0, (relay_dc != prev_dc) && (relay_ac != prev_ac) && (state != 3'd6)}, 0);
      prev_dc <= relay_dc;
      prev_ac <= relay_ac;
    end else begin
      prev_dc <= 1'b0;
      prev_ac <= 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    #3;
    check("reset_relay_dc", {31'd0, relay_dc}, 0);
    check("reset_state", {29'd0, state}, 0);
    #19 rst_n = 1'b1;
    tick(2);
    check("idle_off", {29'd0, state}, 0);

    // Power-up: DC settles 4 cycles, one DC_ON cycle, AC closes at edge 6.
    req_dc = 1'b1;
    tick(1);
    check("e1_dc", {31'd0, relay_dc}, 1);
    check("e1_state", {29'd0, state}, 1);
    check("pin_model_settle", m_state, 1);
    req_ac = 1'b1;
    tick(4);
    check("e5_state", {29'd0, state}, 2);
    check("e5_ac", {31'd0, relay_ac}, 0);
    tick(1);
    check("e6_ac", {31'd0, relay_ac}, 1);
    check("e6_led_ac", {31'd0, led_ac}, 1);

    // Drop both: AC opens, DC opens 3 cycles later, OFF after 5 more.
    req_dc = 1'b0;
    req_ac = 1'b0;
    tick(1);
    check("drop_ac", {31'd0, relay_ac}, 0);
    check("drop_dc_held", {31'd0, relay_dc}, 1);
    tick(2);
    check("gap_dc_held", {31'd0, relay_dc}, 1);
    tick(1);
    check("gap_dc_open", {31'd0, relay_dc}, 0);
    check("holdoff_state", {29'd0, state}, 5);
    tick(4);
    check("holdoff_last", {29'd0, state}, 5);
    tick(1);
    check("holdoff_done", {29'd0, state}, 0);
    check("pin_model_off", m_state, 0);

    // AC re-request during the gap returns to DC_ON, DC never opens.
    req_dc = 1'b1;
    tick(1);
    req_ac = 1'b1;
    tick(5);
    check("c_ac_on", {29'd0, state}, 3);
    req_ac = 1'b0;
    tick(1);
    check("c_drop", {29'd0, state}, 4);
    req_ac = 1'b1;
    tick(2);
    check("c_gap_hold", {29'd0, state}, 4);
    check("c_gap_dc", {31'd0, relay_dc}, 1);
    tick(1);
    check("c_back_dc_on", {29'd0, state}, 2);
    check("c_back_dc", {31'd0, relay_dc}, 1);
    tick(1);
    check("c_ac_again", {31'd0, relay_ac}, 1);

    // E-stop during DC settle.
    req_dc = 1'b0;
    req_ac = 1'b0;
    tick(9);
    check("d_off", {29'd0, state}, 0);
    req_dc = 1'b1;
    tick(2);
    fault_n = 1'b0;
    tick(2);
    check("d_settle_still", {29'd0, state}, 1);
    check("d_dc_still", {31'd0, relay_dc}, 1);
    tick(1);
    check("d_fault_state", {29'd0, state}, 6);
    check("d_fault_dc", {31'd0, relay_dc}, 0);
    check("pin_model_fault", m_state, 6);
    fault_n = 1'b1;
    tick(4);
    check("d_fault_held", {29'd0, state}, 6);
    req_dc = 1'b0;
    tick(1);
    check("d_holdoff", {29'd0, state}, 5);
    tick(4);
    check("d_holdoff_last", {29'd0, state}, 5);
    tick(1);
    check("d_off_again", {29'd0, state}, 0);

    // Requests are ignored in HOLDOFF.
    req_dc = 1'b1;
    tick(1);
    req_dc = 1'b0;
    tick(1);
    check("e_holdoff", {29'd0, state}, 5);
    req_dc = 1'b1;
    tick(1);
    req_dc = 1'b0;
    req_ac = 1'b1;
    tick(1);
    req_ac = 1'b0;
    tick(2);
    check("e_holdoff_pulse", {29'd0, state}, 5);
    req_dc = 1'b1;
    tick(1);
    check("e_off", {29'd0, state}, 0);
    tick(1);
    check("e_restart", {29'd0, state}, 1);

    // Reset in AC_ON opens both relays immediately.
    req_ac = 1'b1;
    tick(4);
    check("f_dc_on", {29'd0, state}, 2);
    tick(1);
    check("f_ac_on", {29'd0, state}, 3);
    check("f_led_dc", {31'd0, led_dc}, 1);
    rst_n = 1'b0;
    #1;
    check("f_rst_dc", {31'd0, relay_dc}, 0);
    check("f_rst_ac", {31'd0, relay_ac}, 0);
    check("f_rst_state", {29'd0, state}, 0);
    req_ac = 1'b0;
    tick(1);
    check("f_in_reset", {29'd0, state}, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("f_no_early_move", {29'd0, state}, 0);
    tick(1);
    check("f_first_edge", {29'd0, state}, 1);
    check("f_first_edge_dc", {31'd0, relay_dc}, 1);
    tick(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
